seq1101_framer_tx: RTL and testbench
====================================

Name: seq1101_framer_tx

Overview:
- Serial transmitter for the 1101 sync-sequence protocol.
- Accepts a parallel payload word via valid/ready and emits one frame on a 1-bit line, one bit per clock:
  - the 4-bit sync header 1101;
  - the payload, MSB first;
  - 0-bit stuffing so the sequence 1101 never occurs after the header.
- Drives the line that the team's 1101 sequence detector/deframer monitors.

Parameters:
- DATA_W, 8, payload width in bits (range 2..32).
- SYNC, 4'b1101, header pattern. Fixed; exposed only so benches can reference it.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_W  payload word; sampled when tx_valid && tx_ready.
- tx_valid  input  1  payload available.
- tx_ready  output  1  framer idle and able to accept a payload.
- out  output  1  serial line, registered.
- out_valid  output  1  high exactly on cycles where out carries a frame bit (header, payload, parity or stuff).
- frame_start  output  1  one-cycle pulse, coincident with the first header bit.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE, out=0, out_valid=0, frame_start=0, busy=0, history=3'b000.
  - Captured payload is discarded; no partial frame resumes.
- tx_ready = (state==IDLE). It is combinational from state and never depends on tx_valid.
- States:
  - IDLE: on tx_valid && tx_ready, load the shift register with tx_data, bit counter=DATA_W-1, go to HDR.
  - HDR: four cycles emitting 1,1,0,1. frame_start=1 on the first cycle only. Then go to PAY.
  - PAY: emit shreg MSB and shift left. The counter decrements.
  - STUFF: emit one 0. Then resume PAY, or go to PAR/IDLE if the payload is exhausted.
  - PAR: optional, see below.
- Latency: the accept cycle is N; first header bit on out is at N+1; the last frame bit is at N+4+DATA_W+stuff_count(+1 parity).
- Stuffing rule:
  - history is a 3-bit shift register of every emitted frame bit, including stuffed bits.
  - After any payload, parity or stuff bit is emitted, if history becomes 3'b110, the next cycle is STUFF.
  - This applies after the final payload/parity bit too, so a trailing stuff bit is possible.
  - Header bits update history but never trigger stuffing. history after the header is always 3'b101.
- Frame end: the cycle after the last frame bit is IDLE with out=0 and out_valid=0. The minimum gap between frames is 1 cycle.
- tx_data and tx_valid are ignored while busy. Changes to tx_data after acceptance have no effect.
- Idle line: out=0.

Optional Feature:
- SEQ1101_PARITY_EN.
- Defined: after the last payload bit (and any stuff bit it triggers), state PAR emits even parity (XOR of the DATA_W payload bits). The parity bit is subject to the same stuffing rule.
- Undefined: the PAR state and the parity register are absent; the frame ends after the payload and any trailing stuff bit.

Decomposition:
- Package seq1101_pkg:
  - state enum {IDLE, HDR, PAY, STUFF, PAR};
  - localparam SYNC_WORD=4'b1101, HDR_LEN=4;
  - function needs_stuff(history) returning history==3'b110.
- The package is shared with the detector/deframer.
- One sub-module, seq1101_stuff_ctl: owns the history register and the stuff request. It is reused by the deframer for destuffing.

Test Plan:
- Reset, then tx_data=8'h00 -> out_valid high 12 cycles; stream 1101 00000000; frame_start only on the first bit; tx_ready low for 12 cycles.
- tx_data=8'hD0 -> stream 1101 1 1 0 [0] 1 0 0 0 0 (13 bits); the stuff bit follows the 3rd payload bit.
- tx_data=8'h66 -> stream 1101 0 1 1 0 [0] 0 1 1 0 [0] (14 bits, including the trailing stuff bit); feeding this stream to the 1101 detector flags only the header.
- Back-to-back frames, tx_valid held high with 8'hFF then 8'h00:
  - first frame is 12 bits, with no stuff;
  - exactly 1 idle cycle (out=0, out_valid=0);
  - second frame is accepted in that idle cycle, so its header starts 2 cycles after the first frame's last bit.
- Assert rst during the 6th frame bit -> out, out_valid and busy drop immediately (async); after release tx_ready=1; the next accepted word produces a full fresh frame.
- SEQ1101_PARITY_EN defined, tx_data=8'h07 -> stream 1101 00000111 then parity 1 (13 bits); undefined -> 12 bits.

Source files
------------

// File: rtl/seq1101_pkg.sv
// Shared definitions for the 1101 sync-sequence framer and deframer.
// States, sync header constants and the stuffing predicate live here.
package seq1101_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        PAY   = 3'd2,
        STUFF = 3'd3,
        PAR   = 3'd4
    } state_t;

    localparam logic [3:0] SYNC_WORD = 4'b1101;
    localparam int         HDR_LEN   = 4;

    // Two ones followed by a zero: one more 1 would complete the sync word.
    function automatic logic needs_stuff(input logic [2:0] history);
        return history == 3'b110;
    endfunction

endpackage

// File: rtl/seq1101_stuff_ctl.sv
// Tracks the last three line bits and requests a stuffed 0 whenever the
// stream could otherwise complete 1101. Shared with the deframer for destuffing.
module seq1101_stuff_ctl
    import seq1101_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_valid,
    input  logic bit_in,
    input  logic check_en,
    output logic stuff_req
);

    logic [2:0] history_reg;
    logic [2:0] history_next;

    // The bit currently on the line is folded in before the test, so the
    // request is available in the same cycle that bit is visible.
    assign history_next = {history_reg[1:0], bit_in};
    assign stuff_req    = check_en && bit_valid && needs_stuff(history_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history_reg <= 3'b000;
        end else if (bit_valid) begin
            history_reg <= history_next;
        end
    end

endmodule

// File: rtl/seq1101_framer_tx.sv
// Serial framer: 1101 header, MSB-first payload, zero stuffing against 1101.
// Optional even parity bit after the payload when SEQ1101_PARITY_EN is defined.
module seq1101_framer_tx
    import seq1101_pkg::*;
#(
    parameter int         DATA_W = 8,
    parameter logic [3:0] SYNC   = SYNC_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              out,
    output logic              out_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);

    // state_reg names the kind of bit currently on out.
    state_t              state_reg;
    logic [DATA_W-1:0]   shreg_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [1:0]          hdr_cnt_reg;
    logic [2:0]          hdr_sr_reg;
`ifdef SEQ1101_PARITY_EN
    logic                par_reg;
    logic                par_done_reg;
`endif

    logic check_en;
    logic stuff_req;

    assign tx_ready = (state_reg == IDLE);
    assign busy     = (state_reg != IDLE);
    assign check_en = (state_reg == PAY) || (state_reg == STUFF) || (state_reg == PAR);

    seq1101_stuff_ctl u_stuff_ctl (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (out_valid),
        .bit_in    (out),
        .check_en  (check_en),
        .stuff_req (stuff_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            cnt_reg      <= '0;
            hdr_cnt_reg  <= 2'd0;
            hdr_sr_reg   <= 3'b000;
            out          <= 1'b0;
            out_valid    <= 1'b0;
            frame_start  <= 1'b0;
`ifdef SEQ1101_PARITY_EN
            par_reg      <= 1'b0;
            par_done_reg <= 1'b0;
`endif
        end else begin
            frame_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    if (tx_valid) begin
                        shreg_reg    <= tx_data;
                        cnt_reg      <= CNT_W'(DATA_W - 1);
                        hdr_cnt_reg  <= 2'd0;
                        hdr_sr_reg   <= SYNC[2:0];
                        out          <= SYNC[3];
                        out_valid    <= 1'b1;
                        frame_start  <= 1'b1;
                        state_reg    <= HDR;
`ifdef SEQ1101_PARITY_EN
                        par_reg      <= ^tx_data;
                        par_done_reg <= 1'b0;
`endif
                    end
                end

                HDR: begin
                    if (hdr_cnt_reg != 2'(HDR_LEN - 1)) begin
                        out         <= hdr_sr_reg[2];
                        hdr_sr_reg  <= {hdr_sr_reg[1:0], 1'b0};
                        hdr_cnt_reg <= hdr_cnt_reg + 2'd1;
                    end else begin
                        // First payload bit; cnt_reg already counts the rest.
                        out       <= shreg_reg[DATA_W-1];
                        shreg_reg <= {shreg_reg[DATA_W-2:0], 1'b0};
                        state_reg <= PAY;
                    end
                end

                PAY, STUFF, PAR: begin
                    if (stuff_req) begin
                        out       <= 1'b0;
                        state_reg <= STUFF;
                    end else if (cnt_reg != '0) begin
                        out       <= shreg_reg[DATA_W-1];
                        shreg_reg <= {shreg_reg[DATA_W-2:0], 1'b0};
                        cnt_reg   <= cnt_reg - 1'b1;
                        state_reg <= PAY;
                    end
`ifdef SEQ1101_PARITY_EN
                    else if (!par_done_reg) begin
                        out          <= par_reg;
                        par_done_reg <= 1'b1;
                        state_reg    <= PAR;
                    end
`endif
                    else begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq1101_framer_tx.sv
// Scoreboard bench for seq1101_framer_tx: a reference framer pushes the
// expected bit stream on acceptance, a negedge monitor pops and compares.
module tb_seq1101_framer_tx;

    typedef struct packed {
        logic b;
        logic first;
    } exp_bit_t;

`ifdef SEQ1101_PARITY_EN
    localparam int L00 = 13, LD0 = 14, L66 = 15, LFF = 14, L07 = 13;
`else
    localparam int L00 = 12, LD0 = 13, L66 = 14, LFF = 12, L07 = 12;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       out;
    logic       out_valid;
    logic       frame_start;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    exp_bit_t exp_q[$];
    logic [2:0] model_hist;
    logic       mon_en = 1'b0;
    int         len = 0;
    int         prev_len = 0;
    int         hits = 0;
    logic [3:0] win = 4'b0000;

    seq1101_framer_tx #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .out         (out),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_bit(input logic b, input logic first, input logic data_bit);
        exp_bit_t e;
        e.b = b;
        e.first = first;
        exp_q.push_back(e);
        model_hist = {model_hist[1:0], b};
        if (data_bit && model_hist == 3'b110) begin
            e.b = 1'b0;
            e.first = 1'b0;
            exp_q.push_back(e);
            model_hist = {model_hist[1:0], 1'b0};
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        logic [3:0] sync_v;
        sync_v = 4'b1101;
        for (int i = 3; i >= 0; i--) push_bit(sync_v[i], i == 3, 1'b0);
        for (int i = 7; i >= 0; i--) push_bit(d[i], 1'b0, 1'b1);
`ifdef SEQ1101_PARITY_EN
        push_bit(^d, 1'b0, 1'b1);
`endif
    endtask

    // Present a word, wait for acceptance, then queue the expected frame.
    task automatic send(input logic [7:0] d, input logic hold, output time acc);
        int t;
        t = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        acc = $time;
        #1;
        push_frame(d);
        tx_valid = hold;
        tx_data  = ~d;
    endtask

    task automatic drain(input string tag, input int exp_len);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) check({tag, "_drain_timeout"}, exp_q.size(), 0);
        @(negedge clk);
        #1;
        check({tag, "_end_valid"}, out_valid, 0);
        check({tag, "_end_out"}, out, 0);
        check({tag, "_len"}, len, exp_len);
        check({tag, "_sync_hits"}, hits, 1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("ready_vs_valid", tx_ready, !out_valid);
            check("busy_vs_valid", busy, out_valid);
            if (out_valid) begin
                if (frame_start) begin
                    prev_len = len;
                    len  = 1;
                    hits = 0;
                    win  = {3'b000, out};
                end else begin
                    len++;
                    win = {win[2:0], out};
                end
                if (win == 4'b1101) hits++;
                if (exp_q.size() == 0) begin
                    check("extra_bit", 1, 0);
                end else begin
                    exp_bit_t e;
                    e = exp_q.pop_front();
                    check("out_bit", out, e.b);
                    check("frame_start", frame_start, e.first);
                end
            end else begin
                check("idle_out", out, 0);
                check("idle_frame_start", frame_start, 0);
                if (exp_q.size() != 0) check("gap", exp_q.size(), 0);
            end
        end
    end

    initial begin
        time a1, a2;
        model_hist = 3'b000;
        #1;
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_ready", tx_ready, 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        mon_en = 1'b1;

        send(8'h00, 1'b0, a1);
        #5;
        check("first_bit_latency", out_valid, 1);
        check("first_bit_fs", frame_start, 1);
        drain("f00", L00);

        send(8'hD0, 1'b0, a1);
        drain("fD0", LD0);

        send(8'h66, 1'b0, a1);
        drain("f66", L66);

        send(8'h07, 1'b0, a1);
        drain("f07", L07);

        // Back-to-back with tx_valid held high; data change while busy is ignored.
        send(8'hFF, 1'b1, a1);
        tx_data = 8'h00;
        send(8'h00, 1'b0, a2);
        check("b2b_accept_spacing", 32'(a2 - a1), 32'((LFF + 1) * 10));
        drain("b2b_second", L00);
        check("b2b_first_len", prev_len, LFF);

        // Asynchronous reset in the middle of the 6th frame bit.
        send(8'hD0, 1'b0, a1);
        repeat (6) @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out", out, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", tx_ready, 1);
        exp_q.delete();
        model_hist = 3'b000;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("postrst_ready", tx_ready, 1);
        @(negedge clk);
        check("postrst_idle_valid", out_valid, 0);
        mon_en = 1'b1;
        send(8'h66, 1'b0, a1);
        drain("postrst_f66", L66);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0t exp=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
